// File: rtl/sme_pkg.sv
// Shared types and constants for the SME loader: FSM state encoding,
// default buffer depths and character/result field widths.
package sme_pkg;

    localparam int unsigned STR_MAX_DEF = 32;
    localparam int unsigned PAT_MAX_DEF = 8;
    localparam int unsigned CHAR_W      = 8;
    localparam int unsigned IDX_W       = 5;

    localparam logic [CHAR_W-1:0] CHAR_NUL = 8'h00;
    localparam logic              KIND_STR = 1'b0;
    localparam logic              KIND_PAT = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StSendStr,
        StSendPat,
        StWait,
        StResult
    } sme_state_e;

endpackage

// File: rtl/sme_loader_if.sv
// Byte-in, matcher and result signals of the SME loader.
// slave = loader side, master = environment side.
interface sme_loader_if;
    import sme_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [CHAR_W-1:0] in_data;
    logic              in_kind;
    logic              in_last;
    logic [CHAR_W-1:0] chardata;
    logic              isstring;
    logic              ispattern;
    logic              sme_valid;
    logic              sme_match;
    logic [IDX_W-1:0]  sme_index;
    logic              res_valid;
    logic              res_ready;
    logic              res_match;
    logic [IDX_W-1:0]  res_index;
    logic              res_err;

    modport slave (
        input  in_valid, in_data, in_kind, in_last, sme_valid, sme_match, sme_index, res_ready,
        output in_ready, chardata, isstring, ispattern, res_valid, res_match, res_index, res_err
    );

    modport master (
        output in_valid, in_data, in_kind, in_last, sme_valid, sme_match, sme_index, res_ready,
        input  in_ready, chardata, isstring, ispattern, res_valid, res_match, res_index, res_err
    );

endinterface

// File: rtl/sme_char_buf.sv
// Flop-array character buffer: one synchronous write port and one
// combinational read port. Contents are not reset.
module sme_char_buf
    import sme_pkg::*;
#(
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [CHAR_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [CHAR_W-1:0] o_rdata
);

    logic [CHAR_W-1:0] r_mem [DEPTH];

    // Write port: store one character when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sme_loader.sv
// SME loader: collects a job's string and pattern bytes, replays them to
// the matcher (string first, then pattern, no gap), waits for the match
// result and holds it until the consumer takes it.
module sme_loader
    import sme_pkg::*;
#(
    parameter int unsigned STR_MAX = STR_MAX_DEF,
    parameter int unsigned PAT_MAX = PAT_MAX_DEF
) (
    input logic         clk,
    input logic         reset,
    sme_loader_if.slave bus
);

    localparam int unsigned MAX_D  = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
    localparam int unsigned CNT_W  = $clog2(MAX_D + 1);
    localparam int unsigned STR_AW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
    localparam int unsigned PAT_AW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

    sme_state_e       r_state;
    logic [CNT_W-1:0] r_str_cnt;
    logic [CNT_W-1:0] r_pat_cnt;
    logic [CNT_W-1:0] r_idx;
    logic             r_err;
    logic             r_saw_pat;
    logic             r_isstring;
    logic             r_ispattern;
    logic             r_res_valid;
    logic             r_res_match;
    logic [IDX_W-1:0] r_res_index;
    logic             r_res_err;

    logic              w_in_ready;
    logic              w_acc;
    logic              w_str_full;
    logic              w_pat_full;
    logic              w_str_we;
    logic              w_pat_we;
    logic              w_drop;
    logic [CNT_W-1:0]  w_str_cnt_nxt;
    logic [CNT_W-1:0]  w_pat_cnt_nxt;
    logic              w_last_str;
    logic              w_last_pat;
    logic [CHAR_W-1:0] w_str_rd;
    logic [CHAR_W-1:0] w_pat_rd;

    assign w_in_ready = (r_state == StIdle) || (r_state == StCollect);
    assign w_acc      = bus.in_valid && w_in_ready;
    assign w_str_full = (r_str_cnt == CNT_W'(STR_MAX));
    assign w_pat_full = (r_pat_cnt == CNT_W'(PAT_MAX));

    // A string byte is kept only if it is not flagged last, no pattern byte
    // preceded it in this job and there is room; anything else is dropped.
    assign w_str_we = w_acc && (bus.in_kind == KIND_STR) && !bus.in_last && !r_saw_pat
                      && !w_str_full;
    assign w_pat_we = w_acc && (bus.in_kind == KIND_PAT) && !w_pat_full;
    assign w_drop   = w_acc && !w_str_we && !w_pat_we;

    assign w_str_cnt_nxt = r_str_cnt + CNT_W'(w_str_we);
    assign w_pat_cnt_nxt = r_pat_cnt + CNT_W'(w_pat_we);
    assign w_last_str    = (r_idx == r_str_cnt - CNT_W'(1));
    assign w_last_pat    = (r_idx == r_pat_cnt - CNT_W'(1));

    sme_char_buf #(
        .DEPTH (STR_MAX)
    ) u_str_buf (
        .clk     (clk),
        .i_we    (w_str_we),
        .i_waddr (r_str_cnt[STR_AW-1:0]),
        .i_wdata (bus.in_data),
        .i_raddr (r_idx[STR_AW-1:0]),
        .o_rdata (w_str_rd)
    );

    sme_char_buf #(
        .DEPTH (PAT_MAX)
    ) u_pat_buf (
        .clk     (clk),
        .i_we    (w_pat_we),
        .i_waddr (r_pat_cnt[PAT_AW-1:0]),
        .i_wdata (bus.in_data),
        .i_raddr (r_idx[PAT_AW-1:0]),
        .o_rdata (w_pat_rd)
    );

    // Job FSM with registered strobes and result payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_str_cnt   <= '0;
            r_pat_cnt   <= '0;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_saw_pat   <= 1'b0;
            r_isstring  <= 1'b0;
            r_ispattern <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_match <= 1'b0;
            r_res_index <= '0;
            r_res_err   <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StCollect: begin
                    if (w_acc) begin
                        r_str_cnt <= w_str_cnt_nxt;
                        r_pat_cnt <= w_pat_cnt_nxt;
                        r_idx     <= '0;
                        if (w_drop) begin
                            r_err <= 1'b1;
                        end
                        if (bus.in_kind == KIND_PAT) begin
                            r_saw_pat <= 1'b1;
                        end
                        if (bus.in_last) begin
                            if (w_pat_cnt_nxt == '0) begin
                                // Nothing to match against: report an error result directly.
                                r_state     <= StResult;
                                r_res_valid <= 1'b1;
                                r_res_match <= 1'b0;
                                r_res_index <= '0;
                                r_res_err   <= 1'b1;
                            end else if (w_str_cnt_nxt != '0) begin
                                r_state    <= StSendStr;
                                r_isstring <= 1'b1;
                            end else begin
                                r_state     <= StSendPat;
                                r_ispattern <= 1'b1;
                            end
                        end else begin
                            r_state <= StCollect;
                        end
                    end
                end
                StSendStr: begin
                    if (w_last_str) begin
                        r_state     <= StSendPat;
                        r_isstring  <= 1'b0;
                        r_ispattern <= 1'b1;
                        r_idx       <= '0;
                    end else begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
                StSendPat: begin
                    if (w_last_pat) begin
                        r_state     <= StWait;
                        r_ispattern <= 1'b0;
                    end else begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
                StWait: begin
                    if (bus.sme_valid) begin
                        r_state     <= StResult;
                        r_res_valid <= 1'b1;
                        r_res_match <= bus.sme_match;
                        r_res_index <= bus.sme_index;
                        r_res_err   <= r_err;
                    end
                end
                StResult: begin
                    if (bus.res_ready) begin
                        r_state     <= StIdle;
                        r_res_valid <= 1'b0;
                        r_str_cnt   <= '0;
                        r_pat_cnt   <= '0;
                        r_idx       <= '0;
                        r_err       <= 1'b0;
                        r_saw_pat   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.isstring  = r_isstring;
    assign bus.ispattern = r_ispattern;
    assign bus.chardata  = r_isstring ? w_str_rd : (r_ispattern ? w_pat_rd : CHAR_NUL);
    assign bus.res_valid = r_res_valid;
    assign bus.res_match = r_res_match;
    assign bus.res_index = r_res_index;
    assign bus.res_err   = r_res_err;

endmodule

// File: tb/tb_sme_loader.sv
// Self-checking bench for sme_loader: directed and random jobs checked
// against a queue-based model of what the matcher should see and report.
module tb_sme_loader;
    import sme_pkg::*;

    localparam int unsigned STR_MAX = 32;
    localparam int unsigned PAT_MAX = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sme_loader_if bus ();

    sme_loader #(
        .STR_MAX (STR_MAX),
        .PAT_MAX (PAT_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    bit          job_kind[$];
    byte unsigned job_data[$];
    byte unsigned exp_str[$];
    byte unsigned exp_pat[$];
    bit          exp_err;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            job_kind.push_back(1'b0);
            job_data.push_back(s[i]);
        end
    endtask

    task automatic add_pat(input string s);
        for (int i = 0; i < s.len(); i++) begin
            job_kind.push_back(1'b1);
            job_data.push_back(s[i]);
        end
    endtask

    // What the matcher should receive and whether the job is in error.
    task automatic model();
        bit seen_pat;
        bit last;
        seen_pat = 1'b0;
        exp_str.delete();
        exp_pat.delete();
        exp_err = 1'b0;
        for (int i = 0; i < job_data.size(); i++) begin
            last = (i == job_data.size() - 1);
            if (job_kind[i] == 1'b0) begin
                if (last || seen_pat || exp_str.size() >= STR_MAX) exp_err = 1'b1;
                else exp_str.push_back(job_data[i]);
            end else begin
                seen_pat = 1'b1;
                if (exp_pat.size() >= PAT_MAX) exp_err = 1'b1;
                else exp_pat.push_back(job_data[i]);
            end
        end
        if (exp_pat.size() == 0) exp_err = 1'b1;
    endtask

    task automatic drive_bytes();
        int n;
        n = job_data.size();
        for (int i = 0; i < n; i++) begin
            check("in_ready_collect", {15'b0, bus.in_ready}, 16'd1);
            bus.in_valid  = 1'b1;
            bus.in_kind   = job_kind[i];
            bus.in_data   = job_data[i];
            bus.in_last   = (i == n - 1);
            bus.sme_valid = 1'($urandom);
            bus.sme_match = 1'($urandom);
            bus.sme_index = 5'($urandom);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.sme_valid = 1'b0;
    endtask

    task automatic run_job(input bit m, input logic [4:0] ix, input int hold);
        int s_n;
        int p_n;
        logic [15:0] e;
        logic [7:0] chr;
        bit em;
        logic [4:0] eix;
        model();
        drive_bytes();
        s_n = exp_str.size();
        p_n = exp_pat.size();
        if (p_n > 0) begin
            for (int c = 0; c <= s_n + p_n; c++) begin
                chr = (c < s_n) ? exp_str[c] : ((c < s_n + p_n) ? exp_pat[c - s_n] : 8'h00);
                e = {4'b0, 1'b0, 1'b0, 1'(c < s_n), 1'(c >= s_n && c < s_n + p_n), chr};
                check("replay", {4'b0, bus.in_ready, bus.res_valid, bus.isstring, bus.ispattern,
                                 bus.chardata}, e);
                if (c < s_n + p_n) begin
                    bus.sme_valid = 1'($urandom);
                    bus.sme_match = 1'($urandom);
                    bus.sme_index = 5'($urandom);
                    step();
                end
            end
            bus.sme_valid = 1'b0;
            for (int w = $urandom_range(0, 3); w > 0; w--) begin
                step();
                check("wait_idle", {4'b0, bus.in_ready, bus.res_valid, bus.isstring,
                                    bus.ispattern, bus.chardata}, 16'h0);
            end
            bus.sme_valid = 1'b1;
            bus.sme_match = m;
            bus.sme_index = ix;
            step();
            bus.sme_valid = 1'b0;
            bus.sme_match = ~m;
            bus.sme_index = ~ix;
            em  = m;
            eix = ix;
        end else begin
            em  = 1'b0;
            eix = 5'd0;
        end
        for (int h = 0; h <= hold; h++) begin
            e = {5'b0, 1'b1, em, eix, exp_err, 1'b0, 1'b0, 1'b0};
            check("result_hold", {5'b0, bus.res_valid, bus.res_match, bus.res_index, bus.res_err,
                                  bus.in_ready, bus.isstring, bus.ispattern}, e);
            bus.res_ready = (h == hold);
            bus.sme_valid = 1'($urandom);
            step();
        end
        bus.res_ready = 1'b0;
        bus.sme_valid = 1'b0;
        check("result_done", {14'b0, bus.res_valid, bus.in_ready}, 16'h1);
        job_kind.delete();
        job_data.delete();
    endtask

    initial begin
        int ns;
        int np;
        int nt;
        bit mix;

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_kind   = 1'b0;
        bus.in_last   = 1'b0;
        bus.sme_valid = 1'b0;
        bus.sme_match = 1'b0;
        bus.sme_index = 5'd0;
        bus.res_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_outputs", {3'b0, bus.res_valid, bus.res_match, bus.res_index, bus.res_err,
                                bus.isstring, bus.ispattern, 3'b0}, 16'h0);
        check("reset_chardata", {8'b0, bus.chardata}, 16'h0);
        step();
        step();
        reset = 1'b0;
        step();
        check("in_ready_after_reset", {15'b0, bus.in_ready}, 16'd1);

        // String "ab cd", pattern "cd".
        add_str("ab cd");
        add_pat("cd");
        run_job(1'b1, 5'd3, 0);

        // Pattern-only job.
        add_pat("^a");
        run_job(1'b0, 5'd1, 1);

        // String overflow: 33 bytes, only 32 kept.
        for (int i = 0; i < 33; i++) add_str("s");
        job_data[32] = 8'h7a;
        add_pat("x");
        run_job(1'b1, 5'd0, 0);

        // String byte after a pattern byte is dropped.
        add_str("ab");
        add_pat("c");
        add_str("d");
        add_pat("e");
        run_job(1'b1, 5'd2, 0);

        // Result held for five cycles without res_ready.
        add_str("xyz");
        add_pat("y");
        run_job(1'b1, 5'd1, 5);

        // No pattern at all; last byte is a string byte.
        add_str("abc");
        run_job(1'b0, 5'd0, 1);

        // Pattern overflow.
        add_str("q");
        add_pat("0123456789");
        run_job(1'b0, 5'd17, 0);

        // Reset in the middle of the string replay.
        add_str("hello");
        add_pat("l");
        model();
        drive_bytes();
        check("sendstr_before_reset", {7'b0, bus.isstring, bus.chardata}, {7'b0, 1'b1, 8'h68});
        step();
        step();
        reset = 1'b1;
        #1;
        check("abort_on_reset", {5'b0, bus.res_valid, bus.isstring, bus.ispattern, bus.chardata},
              16'h0);
        step();
        reset = 1'b0;
        step();
        check("ready_after_abort", {13'b0, bus.in_ready, bus.isstring, bus.ispattern}, 16'h4);
        job_kind.delete();
        job_data.delete();

        add_str("ok");
        add_pat("k");
        run_job(1'b1, 5'd1, 0);

        // Random jobs.
        for (int j = 0; j < 30; j++) begin
            ns  = $urandom_range(0, 35);
            np  = $urandom_range(0, 10);
            mix = ($urandom_range(0, 3) == 0);
            if (ns + np == 0) np = 1;
            nt = ns + np;
            for (int i = 0; i < nt; i++) begin
                if (mix) job_kind.push_back(1'($urandom));
                else job_kind.push_back(i >= ns);
                job_data.push_back(8'($urandom));
            end
            run_job(1'($urandom), 5'($urandom), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
